// File: rtl/div_seq_ctrl.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU sequencer: radix-2 restoring, one quotient bit per cycle, stalls the pipe while busy.
// Optional `DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip the iteration (IDLE->FIX->DONE).
module div_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic [4:0]  rd_addr,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] result,
  output logic [4:0]  resp_rd
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state, state_nxt;
  logic [2:0]  op;
  logic [4:0]  rd_q;
  logic [31:0] dvd;      // dividend shifts out of the top, quotient shifts in at the bottom
  logic [31:0] dvs;
  logic [31:0] rem;
  logic [31:0] raw_dvd;
  logic [4:0]  count;
  logic        neg_q, neg_r, div_zero, ovf;

  logic        op_signed, accept, ovf_in, zero_in, q_bit;
  logic [31:0] dvd_abs, dvs_abs, rem_nxt, q_fix, r_fix, fix_val;
  logic [32:0] rem_sh, rem_sub;

  assign op_signed = ~funct3[0];
  assign accept    = (state == IDLE) && req_valid && !flush;
  assign zero_in   = (divisor == 32'h0);
  assign ovf_in    = op_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
  assign dvd_abs   = (op_signed && dividend[31]) ? -dividend : dividend;
  assign dvs_abs   = (op_signed && divisor[31])  ? -divisor  : divisor;

  // 33-bit partial remainder so unsigned divisors above 2^31 still restore correctly
  assign rem_sh  = {rem, dvd[31]};
  assign rem_sub = rem_sh - {1'b0, dvs};
  assign q_bit   = (rem_sh >= {1'b0, dvs});
  assign rem_nxt = q_bit ? rem_sub[31:0] : rem_sh[31:0];

  assign q_fix = neg_q ? -dvd : dvd;
  assign r_fix = neg_r ? -rem : rem;

  always_comb begin
    fix_val = op[1] ? r_fix : q_fix;
    if (div_zero)
      fix_val = op[1] ? raw_dvd : 32'hFFFF_FFFF;
    else if (ovf)
      fix_val = op[1] ? 32'h0 : 32'h8000_0000;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef DIV_FAST_SPECIAL_EN
          state_nxt = (zero_in || ovf_in) ? FIX : CALC;
`else
          state_nxt = CALC;
`endif
        end
      end
      CALC:    if (count == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op       <= 3'd0;
      rd_q     <= 5'd0;
      dvd      <= 32'd0;
      dvs      <= 32'd0;
      rem      <= 32'd0;
      raw_dvd  <= 32'd0;
      count    <= 5'd0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      result   <= 32'd0;
      resp_rd  <= 5'd0;
    end else if (!flush) begin
      if (accept) begin
        op       <= funct3;
        rd_q     <= rd_addr;
        dvd      <= dvd_abs;
        dvs      <= dvs_abs;
        rem      <= 32'd0;
        raw_dvd  <= dividend;
        count    <= 5'd0;
        neg_q    <= op_signed && (dividend[31] ^ divisor[31]);
        neg_r    <= op_signed && dividend[31];
        div_zero <= zero_in;
        ovf      <= ovf_in;
      end
      if (state == CALC) begin
        rem   <= rem_nxt;
        dvd   <= {dvd[30:0], q_bit};
        count <= count + 5'd1;
      end
      if (state == FIX) begin
        result  <= fix_val;
        resp_rd <= rd_q;
      end
    end
  end

  assign req_ready  = (state == IDLE) && !rst;
  assign stall      = !rst && (((state == IDLE) && req_valid) || (state == CALC) || (state == FIX));
  assign resp_valid = !rst && !flush && (state == DONE);

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: hand-computed results, latency, stall length, flush and reset.
module tb_div_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, flush, req_valid, req_ready, stall, resp_valid;
  logic [2:0]  funct3;
  logic [31:0] dividend, divisor, result;
  logic [4:0]  rd_addr, resp_rd;

  int n_chk = 0;
  int n_pass = 0;

`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPECIAL_LAT = 2;
`else
  localparam int SPECIAL_LAT = 34;
`endif

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  div_seq_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
    .funct3(funct3), .dividend(dividend), .divisor(divisor), .rd_addr(rd_addr),
    .stall(stall), .resp_valid(resp_valid), .result(result), .resp_rd(resp_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
    funct3    = f3;
    dividend  = a;
    divisor   = b;
    rd_addr   = rd;
    req_valid = 1'b1;
    #1;
  endtask

  // Issue from IDLE, wait for the response, check latency, stall length and payload.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                       input int lat_exp);
    int lat, sc;
    drive_req(f3, a, b, rd);
    check({tag, "_stall_acc"}, {31'd0, stall}, 32'd1);
    step();
    req_valid = 1'b0;
    lat = 1;
    sc  = 1;
    check({tag, "_ready_busy"}, {31'd0, req_ready}, 32'd0);
    while (!resp_valid && lat < 100) begin
      if (stall) sc++;
      step();
      lat++;
    end
    check({tag, "_lat"}, lat, lat_exp);
    check({tag, "_stall_len"}, sc, lat_exp);
    check({tag, "_result"}, result, exp);
    check({tag, "_rd"}, {27'd0, resp_rd}, {27'd0, rd});
    check({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
    step();
    check({tag, "_resp_pulse"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0;
    funct3 = 3'd0; dividend = 32'd0; divisor = 32'd0; rd_addr = 5'd0;
    step();
    step();
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_resp_rd", {27'd0, resp_rd}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);

    do_op("divu_100_7",  F_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         34);
    do_op("rem_m7_2",    F_REM,  32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  34);
    do_op("div_m7_2",    F_DIV,  32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD,  34);
    do_op("div_7_m2",    F_DIV,  32'd7,          32'hFFFF_FFFE,  5'd8,  32'hFFFF_FFFD,  34);
    do_op("rem_7_m2",    F_REM,  32'd7,          32'hFFFF_FFFE,  5'd9,  32'd1,          34);
    do_op("div_min_2",   F_DIV,  32'h8000_0000,  32'd2,          5'd10, 32'hC000_0000,  34);
    do_op("divu_big",    F_DIVU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  5'd11, 32'd1,          34);
    do_op("remu_big",    F_REMU, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  5'd12, 32'd1,          34);
    do_op("div_ovf",     F_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h8000_0000,  SPECIAL_LAT);
    do_op("rem_ovf",     F_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'd0,          SPECIAL_LAT);
    do_op("div_by0",     F_DIV,  32'd1234,       32'd0,          5'd15, 32'hFFFF_FFFF,  SPECIAL_LAT);
    do_op("remu_by0",    F_REMU, 32'd1234,       32'd0,          5'd16, 32'd1234,       SPECIAL_LAT);

    // Flush at E+10, then a fresh DIVU 9/3 accepted at E+11 and answered at E+45.
    seen = 0;
    drive_req(F_DIVU, 32'd50, 32'd5, 5'd3);
    step();
    req_valid = 1'b0;
    lat = 1;
    while (lat < 10) begin
      if (resp_valid) seen++;
      step();
      lat++;
    end
    flush = 1'b1;
    #1;
    if (resp_valid) seen++;
    step();
    flush = 1'b0;
    lat++;
    #1;
    check("flush_stall", {31'd0, stall}, 32'd0);
    check("flush_ready", {31'd0, req_ready}, 32'd1);
    drive_req(F_DIVU, 32'd9, 32'd3, 5'd4);
    step();
    req_valid = 1'b0;
    lat++;
    while (!resp_valid && lat < 120) begin
      step();
      lat++;
    end
    check("flush_no_resp", seen, 0);
    check("flush_lat", lat, 45);
    check("flush_result", result, 32'd3);
    check("flush_rd", {27'd0, resp_rd}, 32'd4);
    step();

    // Reset in the middle of DIVU 100/7.
    drive_req(F_DIVU, 32'd100, 32'd7, 5'd9);
    step();
    req_valid = 1'b0;
    for (int i = 1; i < 20; i++) step();
    rst = 1'b1;
    #1;
    check("midrst_stall_now", {31'd0, stall}, 32'd0);
    step();
    check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_resp_rd", {27'd0, resp_rd}, 32'd0);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    rst = 1'b0;
    #1;
    check("midrst_ready", {31'd0, req_ready}, 32'd1);
    step();
    check("midrst_idle_resp", {31'd0, resp_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
